// File: rtl/bcd_scheduler.sv
// Round-robin front end that shares one counting binary-to-BCD converter
// between NUM_REQ requesters, with zero short-circuit and hang recovery.
module bcd_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 65600
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  number_in,
  output logic [NUM_REQ-1:0]     done,
  output logic                   res_valid,
  output logic [ID_W-1:0]        res_id,
  output logic [19:0]            res_digits,
  output logic                   res_err,
  output logic                   bcd_load,
  output logic                   bcd_reset,
  output logic [15:0]            bcd_number,
  input  logic [3:0]             bcd_dig_5,
  input  logic [3:0]             bcd_dig_4,
  input  logic [3:0]             bcd_dig_3,
  input  logic [3:0]             bcd_dig_2,
  input  logic [3:0]             bcd_dig_1,
  input  logic                   bcd_ready,
  output logic [2:0]             state_dbg
);

  // Handshake: a requester raises req with a stable number_in slice and holds
  // both until its one-cycle done pulse; req seen high in the cycle after done
  // is a fresh request, and dropping req after the grant does not abort.

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_IDLE    = 3'd1,
    S_LOAD    = 3'd2,
    S_BUSY    = 3'd3,
    S_RECOVER = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   rr;
  logic [ID_W-1:0]   id_q;
  logic [TW-1:0]     timer;
  logic              seen_low;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [ID_W:0]        gnt_sum;
  logic                 gnt_any;
  logic [ID_W-1:0]      gnt_id;
  logic [15:0]          gnt_num;

  assign state_dbg = state;

  // Rotate the request vector so bit 0 is the rr pointer's requester; the
  // lowest set bit of the rotated vector is the winner.
  always_comb begin
    req_dbl = {req, req} >> rr;
    gnt_sum = '0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    gnt_num = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_any && req_dbl[k]) begin
        gnt_any = 1'b1;
        gnt_sum = {1'b0, rr} + (ID_W+1)'(k);
        if (gnt_sum >= (ID_W+1)'(NUM_REQ))
          gnt_sum = gnt_sum - (ID_W+1)'(NUM_REQ);
        gnt_id = gnt_sum[ID_W-1:0];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == ID_W'(i))
        gnt_num = number_in[i*16 +: 16];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_INIT;
      rr         <= '0;
      id_q       <= '0;
      timer      <= '0;
      seen_low   <= 1'b0;
      done       <= '0;
      res_valid  <= 1'b0;
      res_id     <= '0;
      res_digits <= '0;
      res_err    <= 1'b0;
      bcd_load   <= 1'b0;
      bcd_reset  <= 1'b1;
      bcd_number <= '0;
    end else begin
      done      <= '0;
      res_valid <= 1'b0;
      bcd_load  <= 1'b0;
      bcd_reset <= 1'b0;
      case (state)
        S_INIT: state <= S_IDLE;
        S_IDLE: begin
          if (bcd_ready && gnt_any) begin
            id_q <= gnt_id;
            if (gnt_num == 16'd0) begin
              // The converter cannot count down from zero; answer directly.
              state      <= S_DONE;
              res_valid  <= 1'b1;
              res_id     <= gnt_id;
              res_digits <= '0;
              res_err    <= 1'b0;
              done       <= NUM_REQ'(1) << gnt_id;
            end else begin
              state      <= S_LOAD;
              bcd_load   <= 1'b1;
              bcd_number <= gnt_num;
            end
          end
        end
        S_LOAD: begin
          timer    <= '0;
          seen_low <= 1'b0;
          state    <= S_BUSY;
        end
        S_BUSY: begin
          timer <= timer + 1'b1;
          if (!bcd_ready)
            seen_low <= 1'b1;
          // Ready is trusted only after it has been seen low at least once.
          if (bcd_ready && seen_low) begin
            state      <= S_DONE;
            bcd_number <= '0;
            res_valid  <= 1'b1;
            res_id     <= id_q;
            res_digits <= {bcd_dig_5, bcd_dig_4, bcd_dig_3, bcd_dig_2, bcd_dig_1};
            res_err    <= 1'b0;
            done       <= NUM_REQ'(1) << id_q;
          end else if (timer == TMAX) begin
            state      <= S_RECOVER;
            bcd_number <= '0;
            bcd_reset  <= 1'b1;
          end
        end
        S_RECOVER: begin
          state      <= S_DONE;
          res_valid  <= 1'b1;
          res_id     <= id_q;
          res_digits <= '0;
          res_err    <= 1'b1;
          done       <= NUM_REQ'(1) << id_q;
        end
        S_DONE: begin
          rr    <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_scheduler.sv
// Randomised bench for bcd_scheduler: a counting converter model, a
// spec-level service-order/latency predictor and an expected-result queue.
module tb_bcd_scheduler;

  localparam int NR = 4;
  localparam int EW = 71;  // {cycle[70:39], id[38:37], err[36], num[35:20], dig[19:0]}

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  // main instance, default TIMEOUT
  logic [NR-1:0]   req = '0;
  logic [16*NR-1:0] num_bus = '0;
  logic [NR-1:0]   done;
  logic            res_valid, res_err, bcd_load, bcd_reset;
  logic [1:0]      res_id;
  logic [19:0]     res_digits;
  logic [15:0]     bcd_number;
  logic [2:0]      state_dbg;

  // second instance, short TIMEOUT for hang recovery
  logic [NR-1:0]   t_req = '0;
  logic [16*NR-1:0] t_num_bus = '0;
  logic [NR-1:0]   t_done;
  logic            t_res_valid, t_res_err, t_bcd_load, t_bcd_reset;
  logic [1:0]      t_res_id;
  logic [19:0]     t_res_digits;
  logic [15:0]     t_bcd_number;
  logic [2:0]      t_state_dbg;

  // converter models, index 0 = main, 1 = short-timeout instance
  logic        cv_ready [2];
  int          cv_rem   [2];
  logic [15:0] cv_val   [2];
  logic [19:0] cv_dig   [2];
  logic        cv_hang  [2];
  logic [1:0]  c_rst, c_load;
  logic [15:0] c_num [2];

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  logic [15:0]   num_tab [NR];
  int            rr_m = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_scheduler dut (
    .clk(clk), .reset(reset), .req(req), .number_in(num_bus), .done(done),
    .res_valid(res_valid), .res_id(res_id), .res_digits(res_digits), .res_err(res_err),
    .bcd_load(bcd_load), .bcd_reset(bcd_reset), .bcd_number(bcd_number),
    .bcd_dig_5(cv_dig[0][19:16]), .bcd_dig_4(cv_dig[0][15:12]), .bcd_dig_3(cv_dig[0][11:8]),
    .bcd_dig_2(cv_dig[0][7:4]), .bcd_dig_1(cv_dig[0][3:0]), .bcd_ready(cv_ready[0]),
    .state_dbg(state_dbg)
  );

  bcd_scheduler #(.NUM_REQ(4), .ID_W(2), .TIMEOUT(100)) dut_t (
    .clk(clk), .reset(reset), .req(t_req), .number_in(t_num_bus), .done(t_done),
    .res_valid(t_res_valid), .res_id(t_res_id), .res_digits(t_res_digits), .res_err(t_res_err),
    .bcd_load(t_bcd_load), .bcd_reset(t_bcd_reset), .bcd_number(t_bcd_number),
    .bcd_dig_5(cv_dig[1][19:16]), .bcd_dig_4(cv_dig[1][15:12]), .bcd_dig_3(cv_dig[1][11:8]),
    .bcd_dig_2(cv_dig[1][7:4]), .bcd_dig_1(cv_dig[1][3:0]), .bcd_ready(cv_ready[1]),
    .state_dbg(t_state_dbg)
  );

  function automatic logic [19:0] to_bcd(input int n);
    return {4'(n / 10000), 4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic [EW-1:0] mk(input int c, input int id, input logic err, input int n);
    return {32'(c), 2'(id), err, 16'(n), (err ? 20'd0 : to_bcd(n))};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Counting converter: load takes N busy cycles, then ready with the digits.
  assign c_rst  = {t_bcd_reset, bcd_reset};
  assign c_load = {t_bcd_load, bcd_load};
  assign c_num[0] = bcd_number;
  assign c_num[1] = t_bcd_number;
  initial begin
    for (int k = 0; k < 2; k++) begin
      cv_ready[k] = 1'b1; cv_rem[k] = 0; cv_val[k] = '0; cv_dig[k] = '0; cv_hang[k] = 1'b0;
    end
  end
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (c_rst[k]) begin
        cv_ready[k] <= 1'b1;
        cv_rem[k]   <= 0;
        cv_dig[k]   <= '0;
      end else if (c_load[k] && cv_ready[k]) begin
        cv_ready[k] <= 1'b0;
        cv_rem[k]   <= int'(c_num[k]);
        cv_val[k]   <= c_num[k];
        cv_dig[k]   <= '0;
      end else if (!cv_ready[k] && !cv_hang[k]) begin
        if (cv_rem[k] <= 1) begin
          cv_ready[k] <= 1'b1;
          cv_dig[k]   <= to_bcd(int'(cv_val[k]));
        end else begin
          cv_rem[k] <= cv_rem[k] - 1;
        end
      end
    end
  end

  // Scoreboard: every result strobe must match the head of exp_q.
  always @(negedge clk) begin
    if (reset) begin
      chk("load_reset_excl", 64'(bcd_load & bcd_reset), 64'd0);
      chk("t_load_reset_excl", 64'(t_bcd_load & t_bcd_reset), 64'd0);
      chk("done_vs_valid", 64'(|done), 64'(res_valid));
      if (bcd_load) begin
        if (exp_q.size() == 0) chk("unexpected_load", 64'(bcd_load), 64'd0);
        else chk("load_number", 64'(bcd_number), 64'(exp_q[0][35:20]));
      end
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 64'(res_valid), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("res_id", 64'(res_id), 64'(mon_e[38:37]));
          chk("res_digits", 64'(res_digits), 64'(mon_e[19:0]));
          chk("res_err", 64'(res_err), 64'(mon_e[36]));
          chk("res_cycle", 64'(cyc), 64'(mon_e[70:39]));
          chk("done_onehot", 64'(done), 64'(4'b0001 << mon_e[38:37]));
        end
      end
    end
  end

  // Predict service order from the rr pointer and the latency of each job,
  // then raise the requests and let each requester drop req on its done.
  task automatic run_round(input logic [NR-1:0] mask);
    int g, v, n, budget, last;
    @(negedge clk);
    g = cyc;
    budget = 20;
    last = rr_m;
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = (rr_m + k) % NR;
      if (mask[idx]) begin
        n = int'(num_tab[idx]);
        v = g + ((n == 0) ? 1 : 3 + n);
        exp_q.push_back(mk(v, idx, 1'b0, n));
        g = v + 1;
        last = idx;
        budget += n + 5;
      end
    end
    rr_m = (last + 1) % NR;
    for (int i = 0; i < NR; i++) num_bus[i*16 +: 16] = num_tab[i];
    req = mask;
    while (req != '0 && budget > 0) begin
      @(negedge clk);
      req = req & ~done;
      budget--;
    end
    chk("round_complete", 64'(req), 64'd0);
    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    chk({tag, "_res_id"}, 64'(res_id), 64'd0);
    chk({tag, "_res_digits"}, 64'(res_digits), 64'd0);
    chk({tag, "_res_err"}, 64'(res_err), 64'd0);
    chk({tag, "_bcd_load"}, 64'(bcd_load), 64'd0);
    chk({tag, "_bcd_reset"}, 64'(bcd_reset), 64'd1);
    chk({tag, "_bcd_number"}, 64'(bcd_number), 64'd0);
  endtask

  initial begin
    int c, budget;
    for (int i = 0; i < NR; i++) num_tab[i] = '0;

    // reset state and INIT pulse
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;
    #1 chk("init_bcd_reset", 64'(bcd_reset), 64'd1);
    @(negedge clk);
    chk("idle_bcd_reset", 64'(bcd_reset), 64'd0);

    // hang recovery on the short-timeout instance
    @(negedge clk);
    cv_hang[1] = 1'b1;
    t_num_bus[16 +: 16] = 16'd7;
    t_req = 4'b0010;
    c = cyc;
    budget = 200;
    while (!t_bcd_reset && budget > 0) begin @(negedge clk); budget--; end
    chk("recover_cycle", 64'(cyc), 64'(c + 102));
    chk("recover_no_load", 64'(t_bcd_load), 64'd0);
    @(negedge clk);
    chk("t_err_valid", 64'(t_res_valid), 64'd1);
    chk("t_err_flag", 64'(t_res_err), 64'd1);
    chk("t_err_digits", 64'(t_res_digits), 64'd0);
    chk("t_err_id", 64'(t_res_id), 64'd1);
    chk("t_err_done", 64'(t_done), 64'b0010);
    t_req = '0;
    cv_hang[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    t_num_bus[48 +: 16] = 16'd9;
    t_req = 4'b1000;
    c = cyc;
    budget = 50;
    while (!t_res_valid && budget > 0) begin @(negedge clk); budget--; end
    chk("t_after_cycle", 64'(cyc), 64'(c + 12));
    chk("t_after_err", 64'(t_res_err), 64'd0);
    chk("t_after_digits", 64'(t_res_digits), 64'h00009);
    chk("t_after_id", 64'(t_res_id), 64'd3);
    t_req = '0;

    // directed rounds
    num_tab[0] = 16'd1234; run_round(4'b0001);
    num_tab[2] = 16'd0;    run_round(4'b0100);
    num_tab[3] = 16'd3;    run_round(4'b1000);
    num_tab[0] = 16'd5; num_tab[1] = 16'd6; num_tab[2] = 16'd7; num_tab[3] = 16'd8;
    run_round(4'b1111);
    num_tab[0] = 16'd42;   run_round(4'b0001);
    num_tab[1] = 16'd65535; run_round(4'b0010);

    // randomised rounds
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < NR; i++)
        num_tab[i] = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
      run_round(4'($urandom_range(1, 15)));
    end

    // asynchronous reset in the middle of a 500 conversion
    @(negedge clk);
    exp_q.push_back(mk(cyc + 503, 0, 1'b0, 500));
    num_bus[0 +: 16] = 16'd500;
    req = 4'b0001;
    repeat (50) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    req = '0;
    #1 check_reset_outputs("abort");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    rr_m = 0;
    #1 chk("reinit_bcd_reset", 64'(bcd_reset), 64'd1);
    @(negedge clk);
    chk("reidle_bcd_reset", 64'(bcd_reset), 64'd0);
    num_tab[0] = 16'd500;
    run_round(4'b0001);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
